// File: rtl/axis_slew_limiter.sv
// Slew-rate limiter for signed X/Y/Z coordinates.
// Deadbanded target capture, tick-paced ramp, MOVING/SETTLED status.
module axis_slew_limiter #(
  parameter int DATA_WIDTH  = 10,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int UPDATE_FREQ = 1_000,
  parameter int MAX_STEP    = 4,
  parameter int DEADBAND    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         snap,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic signed [DATA_WIDTH-1:0] z_in,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic signed [DATA_WIDTH-1:0] z_out,
  output logic                         moving,
  output logic                         settled
);

  localparam int DW       = DATA_WIDTH;
  localparam int TICK_DIV = CLK_FREQ / UPDATE_FREQ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam int LAST     = TICK_DIV - 1;

  localparam logic [CW-1:0] LP_LAST =
    LAST[CW-1:0];
  localparam logic signed [DW:0] LP_STEP =
    MAX_STEP[DW:0];
  localparam logic signed [DW-1:0] LP_STEP_N =
    MAX_STEP[DW-1:0];
  localparam logic signed [DW:0] LP_DB =
    DEADBAND[DW:0];

  typedef enum logic {
    ST_SETTLED,
    ST_MOVING
  } state_t;

  logic signed [DW-1:0] w_in  [3];
  logic signed [DW-1:0] r_tgt [3];
  logic signed [DW-1:0] r_out [3];
  logic [CW-1:0]        r_cnt;
  logic                 w_tick;
  logic                 w_diff;
  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_settled;
  logic                 w_settled_nxt;

  // One bit wider than the data so differences never wrap.
  function automatic logic f_cap(
    input logic signed [DW-1:0] i,
    input logic signed [DW-1:0] t
  );
    logic signed [DW:0] d;
    d = $signed({i[DW-1], i}) - $signed({t[DW-1], t});
    return (d > LP_DB) || (d < -LP_DB);
  endfunction

  function automatic logic signed [DW-1:0] f_ramp(
    input logic signed [DW-1:0] o,
    input logic signed [DW-1:0] t
  );
    logic signed [DW:0] d;
    d = $signed({t[DW-1], t}) - $signed({o[DW-1], o});
    if (d > LP_STEP)
      return o + LP_STEP_N;
    else if (d < -LP_STEP)
      return o - LP_STEP_N;
    else
      return t;
  endfunction

  assign w_in[0] = x_in;
  assign w_in[1] = y_in;
  assign w_in[2] = z_in;

  assign w_tick = enable && (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      for (int a = 0; a < 3; a++) begin
        r_tgt[a] <= '0;
        r_out[a] <= '0;
      end
    end else if (snap) begin
      r_cnt <= '0;
      for (int a = 0; a < 3; a++) begin
        r_tgt[a] <= w_in[a];
        r_out[a] <= w_in[a];
      end
    end else begin
      if (!enable || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      for (int a = 0; a < 3; a++) begin
        if (f_cap(w_in[a], r_tgt[a]))
          r_tgt[a] <= w_in[a];
        if (w_tick)
          r_out[a] <= f_ramp(r_out[a], r_tgt[a]);
      end
    end
  end

  always_comb begin
    w_diff = 1'b0;
    for (int a = 0; a < 3; a++)
      if (r_out[a] != r_tgt[a])
        w_diff = 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_settled_nxt = 1'b0;
    unique case (r_state)
      ST_SETTLED: begin
        if (w_diff)
          w_state_nxt = ST_MOVING;
      end
      ST_MOVING: begin
        if (!w_diff) begin
          w_state_nxt   = ST_SETTLED;
          w_settled_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_SETTLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SETTLED;
      r_settled <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_settled <= w_settled_nxt;
    end
  end

  assign x_out   = r_out[0];
  assign y_out   = r_out[1];
  assign z_out   = r_out[2];
  assign moving  = (r_state == ST_MOVING);
  assign settled = r_settled;

endmodule

// File: tb/tb_axis_slew_limiter.sv
// Scoreboard bench for axis_slew_limiter: every output or
// status change is popped from a queue and checked with its gap.
module tb_axis_slew_limiter;

  localparam int DW = 10;
  localparam int ST_IDLE = 0;
  localparam int ST_PUL  = 1;
  localparam int ST_MOV  = 2;

  logic clk = 1'b0;
  logic rst, enable, snap;
  logic signed [DW-1:0] x_in, y_in, z_in;
  logic signed [DW-1:0] x_out, y_out, z_out;
  logic moving, settled;

  always #5 clk = ~clk;

  axis_slew_limiter #(
    .DATA_WIDTH (DW),
    .CLK_FREQ   (1000),
    .UPDATE_FREQ(100),
    .MAX_STEP   (4),
    .DEADBAND   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .snap   (snap),
    .x_in   (x_in),
    .y_in   (y_in),
    .z_in   (z_in),
    .x_out  (x_out),
    .y_out  (y_out),
    .z_out  (z_out),
    .moving (moving),
    .settled(settled)
  );

  typedef struct {
    int v;
    int gap;
  } exp_t;

  exp_t qx[$], qy[$], qz[$], qs[$];
  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;
  bit mon_on = 1'b0;
  bit primed = 1'b0;
  int px, py, pz, ps;
  int lx, ly, lz, ls;

  always @(posedge clk) ncyc++;

  task automatic push(input int a, input int v, input int g);
    exp_t e;
    e.v = v;
    e.gap = g;
    case (a)
      0: qx.push_back(e);
      1: qy.push_back(e);
      2: qz.push_back(e);
      default: qs.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int a, input int act, input int g);
    exp_t e;
    bit ok;
    string nm;
    ok = 1'b0;
    e.v = 0;
    e.gap = 0;
    case (a)
      0: begin
        nm = "x_out";
        if (qx.size() > 0) begin e = qx.pop_front(); ok = 1'b1; end
      end
      1: begin
        nm = "y_out";
        if (qy.size() > 0) begin e = qy.pop_front(); ok = 1'b1; end
      end
      2: begin
        nm = "z_out";
        if (qz.size() > 0) begin e = qz.pop_front(); ok = 1'b1; end
      end
      default: begin
        nm = "status{moving,settled}";
        if (qs.size() > 0) begin e = qs.pop_front(); ok = 1'b1; end
      end
    endcase
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s unexpected change: got %0d, required no change",
               nm, act);
    end else if (act != e.v || (e.gap != 0 && g != e.gap)) begin
      nerr++;
      $display("FAIL %s: got %0d after %0d cycles, required %0d after %0d cycles",
               nm, act, g, e.v, e.gap);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor: every observed change pops one expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!primed) begin
        px = int'(x_out); py = int'(y_out); pz = int'(z_out);
        ps = int'({moving, settled});
        lx = ncyc; ly = ncyc; lz = ncyc; ls = ncyc;
        primed = 1'b1;
      end else begin
        if (int'(x_out) != px) begin
          pop_cmp(0, int'(x_out), ncyc - lx);
          px = int'(x_out); lx = ncyc;
        end
        if (int'(y_out) != py) begin
          pop_cmp(1, int'(y_out), ncyc - ly);
          py = int'(y_out); ly = ncyc;
        end
        if (int'(z_out) != pz) begin
          pop_cmp(2, int'(z_out), ncyc - lz);
          pz = int'(z_out); lz = ncyc;
        end
        if (int'({moving, settled}) != ps) begin
          pop_cmp(3, int'({moving, settled}), ncyc - ls);
          ps = int'({moving, settled}); ls = ncyc;
        end
      end
    end
  end

  task automatic wait_x(input int v, input int budget);
    int n;
    n = 0;
    while (int'(x_out) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait x_out", int'(x_out), v);
  endtask

  task automatic push_pulse();
    push(3, ST_PUL, 0);
    push(3, ST_IDLE, 1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; snap = 1'b0;
    x_in = 10'sd123; y_in = 10'sd123; z_in = 10'sd123;

    // Reset with non-zero inputs
    repeat (3) @(negedge clk);
    chk("reset x_out", int'(x_out), 0);
    chk("reset y_out", int'(y_out), 0);
    chk("reset z_out", int'(z_out), 0);
    chk("reset moving", int'(moving), 0);
    chk("reset settled", int'(settled), 0);
    push(3, ST_MOV, 0);
    push_pulse();
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    x_in = '0; y_in = '0; z_in = '0;
    @(negedge clk);
    chk("moving after release", int'(moving), 1);
    repeat (5) @(negedge clk);

    // Positive ramp 0 -> 100
    push(3, ST_MOV, 0);
    for (int k = 1; k <= 25; k++) push(0, 4 * k, (k == 1) ? 0 : 10);
    push_pulse();
    x_in = 10'sd100;
    repeat (300) @(negedge clk);
    chk("ramp x_out", int'(x_out), 100);
    chk("ramp y_out", int'(y_out), 0);
    chk("ramp z_out", int'(z_out), 0);

    // Negative remainder on y
    push(3, ST_MOV, 0);
    push(1, -4, 0);
    push(1, -8, 10);
    push(1, -10, 10);
    push_pulse();
    y_in = -10'sd10;
    repeat (50) @(negedge clk);
    chk("neg y_out", int'(y_out), -10);

    // Full-scale z ramp -512 -> 511
    push(2, -512, 0);
    z_in = -10'sd512;
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    push(3, ST_MOV, 0);
    for (int k = 1; k <= 255; k++) push(2, -512 + 4 * k, 10);
    push(2, 511, 10);
    push_pulse();
    z_in = 10'sd511;
    repeat (2650) @(negedge clk);
    chk("extreme z_out", int'(z_out), 511);

    // Deadband
    x_in = 10'sd101; repeat (5) @(negedge clk);
    x_in = 10'sd98;  repeat (5) @(negedge clk);
    x_in = 10'sd102; repeat (5) @(negedge clk);
    chk("deadband moving", int'(moving), 0);
    chk("deadband x_out", int'(x_out), 100);
    push(3, ST_MOV, 0);
    push(0, 103, 0);
    push_pulse();
    x_in = 10'sd103;
    repeat (25) @(negedge clk);
    chk("deadband exit x_out", int'(x_out), 103);

    // Snap during ramp
    push(0, 0, 0);
    x_in = '0;
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    repeat (3) @(negedge clk);
    push(3, ST_MOV, 0);
    for (int k = 1; k <= 10; k++) push(0, 4 * k, (k == 1) ? 0 : 10);
    x_in = 10'sd100;
    wait_x(40, 200);
    push(0, -300, 0);
    push(3, ST_PUL, 0);
    push(3, ST_MOV, 1);
    push(0, -296, 10);
    push(0, -292, 10);
    push(0, -290, 10);
    push_pulse();
    x_in = -10'sd300;
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    x_in = -10'sd290;
    repeat (45) @(negedge clk);
    chk("snap ramp x_out", int'(x_out), -290);

    // Freeze with enable=0, resume, then reset mid-ramp
    push(0, 0, 0);
    x_in = '0;
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    repeat (3) @(negedge clk);
    push(3, ST_MOV, 0);
    for (int k = 1; k <= 15; k++) push(0, 4 * k, (k == 1) ? 0 : 10);
    x_in = 10'sd100;
    wait_x(60, 250);
    push(0, 64, 60);
    enable = 1'b0;
    repeat (50) @(negedge clk);
    chk("frozen x_out", int'(x_out), 60);
    chk("frozen moving", int'(moving), 1);
    enable = 1'b1;
    wait_x(64, 30);
    push(0, 0, 0);
    push(1, 0, 0);
    push(2, 0, 0);
    push(3, ST_IDLE, 0);
    rst = 1'b1;
    x_in = '0; y_in = '0; z_in = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst x_out", int'(x_out), 0);
    chk("rst y_out", int'(y_out), 0);
    chk("rst z_out", int'(z_out), 0);
    chk("rst moving", int'(moving), 0);
    chk("rst settled", int'(settled), 0);
    repeat (30) @(negedge clk);

    chk("qx drained", qx.size(), 0);
    chk("qy drained", qy.size(), 0);
    chk("qz drained", qz.size(), 0);
    chk("qs drained", qs.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
